instr_fetch_stage: RTL and testbench

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one-outstanding imem requester that feeds the IF/ID register.
// Define FETCH_MISALIGN_CHECK_EN to add misalign_o, a 1-cycle flag for redirects to unaligned targets.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] hold_buf;
  logic            kill;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redirect_tgt;

  assign pc_next       = fetch_pc + XLEN'(4);
  assign redirect_tgt  = redirect_pc & WORD_MASK;
  assign imem_req_addr = fetch_pc;

  // Fetch FSM and IF/ID register; redirect outranks stall and every other input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      fetch_pc       <= RESET_PC;
      kill           <= 1'b0;
      hold_buf       <= '0;
      imem_req_valid <= 1'b1;
      instr_o        <= NOP_INSTR;
      pc_o           <= '0;
      pc_plus4_o     <= XLEN'(4);
      instr_valid_o  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc      <= redirect_tgt;
      instr_o       <= NOP_INSTR;
      instr_valid_o <= 1'b0;
      case (state)
        S_REQ: begin
          // An address accepted this cycle is stale; its response must be dropped.
          if (imem_req_ready) begin
            state          <= S_WAIT;
            kill           <= 1'b1;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state          <= S_REQ;
            kill           <= 1'b0;
            imem_req_valid <= 1'b1;
          end else begin
            kill <= 1'b1;
          end
        end
        default: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end
      endcase
    end else begin
      // Decode consumes the slot whenever it is not stalled; refill below if data is ready.
      if (!stall_i) begin
        instr_o       <= NOP_INSTR;
        instr_valid_o <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill) begin
              kill           <= 1'b0;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else if (!stall_i) begin
              instr_o        <= imem_rsp_data;
              pc_o           <= fetch_pc;
              pc_plus4_o     <= pc_next;
              instr_valid_o  <= 1'b1;
              fetch_pc       <= pc_next;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              hold_buf <= imem_rsp_data;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            instr_o        <= hold_buf;
            pc_o           <= fetch_pc;
            pc_plus4_o     <= pc_next;
            instr_valid_o  <= 1'b1;
            fetch_pc       <= pc_next;
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
          end
        end
        default: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Single-cycle flag for a redirect whose target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a memory model pushes accepted addresses, the
// monitor pops them when IF/ID loads, and redirects/resets discard what is still in flight.
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = RESET_PC;
  int          n_deliv = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_p4 = '0;
  int          rsp_delay = 0;

  instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .instr_valid_o  (instr_valid_o)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    rsp_delay      = 0;
    #1;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd4);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    rst_n   = 1'b1;
    n_deliv = 0;
    chk("req_valid_after_rst", 32'(imem_req_valid), 32'd1);
  endtask

  // Monitor, scoreboard and zero/N-wait-state memory model.
  initial begin : mon
    logic        s_acc, s_red, s_stall, s_rst, s_vld;
    logic [31:0] s_addr, s_rpc, s_instr, s_pc, s_p4, a;
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt  = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      #4;
      s_acc   = imem_req_valid && imem_req_ready;
      s_addr  = imem_req_addr;
      s_red   = redirect_valid;
      s_rpc   = redirect_pc;
      s_stall = stall_i;
      s_rst   = rst_n;
      s_vld   = instr_valid_o;
      s_instr = instr_o;
      s_pc    = pc_o;
      s_p4    = pc_plus4_o;
      @(posedge clk);
      #1;
      if (!s_rst || !rst_n) begin
        exp_q.delete();
        exp_addr = RESET_PC;
      end else begin
        if (s_acc) chk("req_addr", s_addr, exp_addr);
        if (s_red) begin
          exp_q.delete();
          exp_addr = s_rpc & 32'hFFFF_FFFC;
          chk("flush_valid", 32'(instr_valid_o), 32'd0);
          chk("flush_instr", instr_o, NOP);
        end else begin
          if (s_acc) exp_q.push_back(s_addr);
          if (s_stall) begin
            chk("hold_valid", 32'(instr_valid_o), 32'(s_vld));
            chk("hold_instr", instr_o, s_instr);
            chk("hold_pc", pc_o, s_pc);
            chk("hold_pc4", pc_plus4_o, s_p4);
          end else if (instr_valid_o) begin
            chk("deliv_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
              a = exp_q.pop_front();
              chk("deliv_pc", pc_o, a);
              chk("deliv_instr", instr_o, mem_word(a));
              chk("deliv_pc4", pc_plus4_o, 32'(a + 32'd4));
              exp_addr = 32'(a + 32'd4);
              n_deliv++;
              last_pc = pc_o;
              last_p4 = pc_plus4_o;
            end
          end else begin
            chk("bubble_instr", instr_o, NOP);
          end
        end
      end
      // Memory keeps its in-flight response across reset so it can arrive late.
      if (s_acc && s_rst) begin
        pend  = 1'b1;
        cnt   = rsp_delay;
        paddr = s_addr;
      end
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    // Zero wait states: 100,104,108 at one instruction per two cycles.
    do_reset();
    cycles(6);
    chk("t1_count", 32'(n_deliv), 32'd3);
    chk("t1_last_pc", last_pc, 32'h108);

    // Stall across the response for 104.
    do_reset();
    cycles(2);
    stall_i = 1'b1;
    cycles(3);
    chk("t2_held_pc", pc_o, 32'h100);
    stall_i = 1'b0;
    cycles(1);
    chk("t2_count", 32'(n_deliv), 32'd2);
    chk("t2_last_pc", last_pc, 32'h104);
    cycles(2);
    chk("t2_count_next", 32'(n_deliv), 32'd3);
    chk("t2_next_pc", last_pc, 32'h108);

    // Redirect while waiting for 108, response two cycles late.
    do_reset();
    cycles(4);
    rsp_delay = 2;
    cycles(1);
    rsp_delay = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycles(1);
    redirect_valid = 1'b0;
    cycles(4);
    chk("t3_count", 32'(n_deliv), 32'd3);
    chk("t3_last_pc", last_pc, 32'h200);

    // Redirect coinciding with the response.
    do_reset();
    cycles(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cycles(1);
    redirect_valid = 1'b0;
    cycles(2);
    chk("t4_count", 32'(n_deliv), 32'd2);
    chk("t4_last_pc", last_pc, 32'h300);

    // Redirect while stalled with a buffered response.
    do_reset();
    cycles(2);
    stall_i = 1'b1;
    cycles(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cycles(1);
    redirect_valid = 1'b0;
    stall_i        = 1'b0;
    cycles(3);
    chk("t5_count", 32'(n_deliv), 32'd2);
    chk("t5_last_pc", last_pc, 32'h400);

    // Request not accepted for five cycles.
    do_reset();
    cycles(2);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("t6_addr_stable", imem_req_addr, 32'h104);
      chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
    end
    chk("t6_no_update", 32'(n_deliv), 32'd1);
    imem_req_ready = 1'b1;
    cycles(2);
    chk("t6_count", 32'(n_deliv), 32'd2);
    chk("t6_last_pc", last_pc, 32'h104);

    // Reset pulsed in WAIT; the late response must be ignored.
    do_reset();
    cycles(2);
    rsp_delay = 3;
    cycles(1);
    imem_req_ready = 1'b0;
    rsp_delay      = 0;
    rst_n          = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("t7_rst_instr", instr_o, NOP);
    chk("t7_rst_pc", pc_o, 32'd0);
    chk("t7_rst_addr", imem_req_addr, RESET_PC);
    cycles(1);
    rst_n   = 1'b1;
    n_deliv = 0;
    chk("t7_req_valid", 32'(imem_req_valid), 32'd1);
    cycles(4);
    chk("t7_late_ignored", 32'(n_deliv), 32'd0);
    imem_req_ready = 1'b1;
    cycles(2);
    chk("t7_count", 32'(n_deliv), 32'd1);
    chk("t7_last_pc", last_pc, RESET_PC);

    // Unaligned redirect target is forced to a word boundary.
    do_reset();
    cycles(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    cycles(1);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t8_misalign_pulse", 32'(misalign_o), 32'd1);
`endif
    cycles(1);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t8_misalign_clear", 32'(misalign_o), 32'd0);
`endif
    cycles(2);
    chk("t8_count", 32'(n_deliv), 32'd2);
    chk("t8_last_pc", last_pc, 32'h200);

    // pc_plus4 wraps at the top of the address space.
    do_reset();
    cycles(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycles(1);
    redirect_valid = 1'b0;
    cycles(3);
    chk("t9_last_pc", last_pc, 32'hFFFF_FFFC);
    chk("t9_pc4_wrap", last_p4, 32'd0);
    cycles(1);
    chk("t9_next_addr", imem_req_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
